vga_pmod_monitor: RTL and testbench

Receive-side monitor for the TinyVGA Pmod bus that our top levels drive on `uo_out`. It re-samples the 8-bit bus and unscrambles the sync and RGB222 bits. It locks to 640x480@60 timing, emits a per-pixel stream with coordinates, flags timing violations, and produces a per-frame CRC. It sits in the test harness and on-board self-test path as the consumer of a display core's output, clocked by the same pixel clock.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_pmod_monitor_crc.sv | 22 ++
 rtl/vga_pmod_monitor.sv | 187 ++++++++++++++++++
 tb/tb_vga_pmod_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing, TinyVGA Pmod bit map and monitor FSM states.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned H_TOT_DEF    = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned V_TOT_DEF    = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

  // Pmod bus bit positions; syncs are active-low.
  localparam int unsigned BIT_HS = 7;
  localparam int unsigned BIT_VS = 3;
  localparam int unsigned BIT_R1 = 0;
  localparam int unsigned BIT_R0 = 4;
  localparam int unsigned BIT_G1 = 1;
  localparam int unsigned BIT_G0 = 5;
  localparam int unsigned BIT_B1 = 2;
  localparam int unsigned BIT_B0 = 6;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    SEARCH,
    LINE_LOCK,
    LOCKED
  } mon_state_t;

endpackage

// File: rtl/vga_pmod_monitor_crc.sv
// Combinational CRC-16-CCITT step over one 6-bit word, MSB first.
module crc16_ccitt_6b
  import vga_timing_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [5:0]  data,
  output logic [15:0] crc_next_c
);

  // Bit-serial shift unrolled across the six data bits.
  always_comb begin
    crc_next_c = crc;
    for (int i = 5; i >= 0; i--) begin
      if (crc_next_c[15] ^ data[i]) begin
        crc_next_c = {crc_next_c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next_c = {crc_next_c[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/vga_pmod_monitor.sv
// Receive-side TinyVGA Pmod monitor: lock to timing, emit pixels, check timing, frame CRC.
module vga_pmod_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE - 1;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE - 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [7:0]    s_cur;
  logic          hs_prev, vs_prev;
  logic          hs_fall_c, hs_rise_c, vs_fall_c;
  logic [5:0]    rgb_c;
  logic [CW-1:0] h_q, v_q, h_nxt_c, v_nxt_c;
  logic [5:0]    rgb_q;
  logic          le_c, fe_c, le_q, fe_q, fs_q;
  logic          act_c, last_pix_c;
  logic [8:0]    err_sum_c;
  logic [15:0]   crc_q, crc_nxt_c;
  mon_state_t    state_q, state_nxt;

  // Input register; only the sync bits of the previous sample are needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cur   <= '1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      s_cur   <= vga_in;
      hs_prev <= s_cur[BIT_HS];
      vs_prev <= s_cur[BIT_VS];
    end
  end

  assign hs_fall_c = hs_prev & ~s_cur[BIT_HS];
  assign hs_rise_c = ~hs_prev & s_cur[BIT_HS];
  assign vs_fall_c = vs_prev & ~s_cur[BIT_VS];
  assign rgb_c     = {s_cur[BIT_R1], s_cur[BIT_R0], s_cur[BIT_G1],
                      s_cur[BIT_G0], s_cur[BIT_B1], s_cur[BIT_B0]};

  // Position counters for the current sample; vsync fall overrides the line step.
  always_comb begin
    h_nxt_c = (h_q == CNT_MAX) ? h_q : h_q + CW'(1);
    if (hs_fall_c) h_nxt_c = '0;
    v_nxt_c = v_q;
    if (vs_fall_c) begin
      v_nxt_c = '0;
    end else if (hs_fall_c && v_q != CNT_MAX) begin
      v_nxt_c = v_q + CW'(1);
    end
  end

  // Timing checks: hsync period and width once tracking, frame length once locked.
  always_comb begin
    le_c = 1'b0;
    fe_c = 1'b0;
    if (state_q != SEARCH) begin
      le_c = (hs_fall_c && h_q != CW'(H_TOT - 1)) ||
             (hs_rise_c && h_nxt_c != CW'(H_SYNC));
    end
    if (state_q == LOCKED) begin
      fe_c = vs_fall_c && v_q != CW'(V_TOT - 1);
    end
  end

  // Lock FSM next state.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      SEARCH:    if (hs_fall_c) state_nxt = LINE_LOCK;
      LINE_LOCK: if (vs_fall_c) state_nxt = LOCKED;
      LOCKED:    if (le_c)      state_nxt = SEARCH;
      default:                  state_nxt = SEARCH;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_nxt;
  end

  // Decode stage: counters, colour and event flags aligned to one sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
      le_q  <= 1'b0;
      fe_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_nxt_c;
      v_q   <= v_nxt_c;
      rgb_q <= rgb_c;
      le_q  <= le_c;
      fe_q  <= fe_c;
      fs_q  <= vs_fall_c;
    end
  end

  assign act_c = (state_q == LOCKED) &&
                 h_q >= CW'(H_START) && h_q <= CW'(H_END) &&
                 v_q >= CW'(V_START) && v_q <= CW'(V_END);
  assign err_sum_c  = 9'(err_count) + 9'(le_q) + 9'(fe_q);
  assign last_pix_c = pix_valid && pix_x == CW'(H_ACTIVE - 1) && pix_y == CW'(V_ACTIVE - 1);

  crc16_ccitt_6b u_crc (
    .crc        (crc_q),
    .data       (rgb_q),
    .crc_next_c (crc_nxt_c)
  );

  // Output stage: pixel stream, status pulses and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      pix_valid   <= act_c;
      if (act_c) begin
        pix_x   <= h_q - CW'(H_START);
        pix_y   <= v_q - CW'(V_START);
        pix_rgb <= rgb_q;
      end
      frame_start <= fs_q;
      locked      <= (state_q == LOCKED);
      line_err    <= le_q;
      frame_err   <= fe_q;
      err_count   <= (err_sum_c > 9'd255) ? 8'hFF : err_sum_c[7:0];
    end
  end

  // Running frame CRC, published one clock after the last active pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q           <= CRC_INIT;
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
    end else begin
      if (fs_q) begin
        crc_q <= CRC_INIT;
      end else if (act_c) begin
        crc_q <= crc_nxt_c;
      end
      frame_crc_valid <= last_pix_c;
      if (last_pix_c) frame_crc <= crc_q;
    end
  end

endmodule

// File: tb/tb_vga_pmod_monitor.sv
// Directed bench for vga_pmod_monitor using a reduced video timing.
module tb_vga_pmod_monitor;

  // Reduced timing: 30 clocks per line, 15 lines per frame.
  localparam int HA  = 16;
  localparam int HF  = 4;
  localparam int HS  = 6;
  localparam int HB  = 4;
  localparam int VA  = 8;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int HT  = 30;
  localparam int VT  = 15;
  localparam int HST = 10;
  localparam int VST = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'hFF;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic        frame_start, locked, line_err, frame_err;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;
  logic        frame_crc_valid;

  vga_pmod_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vga_in          (vga_in),
    .pix_valid       (pix_valid),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_rgb         (pix_rgb),
    .frame_start     (frame_start),
    .locked          (locked),
    .line_err        (line_err),
    .frame_err       (frame_err),
    .err_count       (err_count),
    .frame_crc       (frame_crc),
    .frame_crc_valid (frame_crc_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: event counts and per-pixel coordinate/colour checks.
  int pv_n = 0, le_n = 0, fe_n = 0, fs_n = 0, fcv_n = 0;
  int seq_bad = 0, rgb_bad = 0;
  int last_x = 0, last_y = 0, ex = 0, ey = 0;
  int lock_cyc = -1, le_cyc = -1, fe_cyc = -1;
  logic [5:0] last_rgb = 6'd0;
  logic [5:0] exp_rgb = 6'd0;
  logic       locked_d = 1'b0;

  always @(negedge clk) begin
    locked_d <= locked;
    if (locked && !locked_d) lock_cyc <= cyc;
    if (line_err) begin le_n <= le_n + 1; le_cyc <= cyc; end
    if (frame_err) begin fe_n <= fe_n + 1; fe_cyc <= cyc; end
    if (frame_crc_valid) fcv_n <= fcv_n + 1;
    if (frame_start) begin
      fs_n <= fs_n + 1;
      ex   <= 0;
      ey   <= 0;
    end else if (pix_valid) begin
      pv_n <= pv_n + 1;
      if (int'(pix_x) != ex || int'(pix_y) != ey) seq_bad <= seq_bad + 1;
      if (pix_rgb != exp_rgb) rgb_bad <= rgb_bad + 1;
      last_x   <= int'(pix_x);
      last_y   <= int'(pix_y);
      last_rgb <= pix_rgb;
      if (ex == HA - 1) begin
        ex <= 0;
        ey <= (ey == VA - 1) ? 0 : ey + 1;
      end else begin
        ex <= ex + 1;
      end
    end
  end

  int total = 0, bad = 0;
  int t_vs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, line_err,
             frame_err, err_count, frame_crc, frame_crc_valid};
  endfunction

  function automatic logic [15:0] crc_model(input int npix, input logic [5:0] rgb);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int n = 0; n < npix; n++) begin
      for (int b = 5; b >= 0; b--) begin
        fb = c[15] ^ rgb[b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Drives samples p0..p1-1 of line ln; data bits appear only in the active window.
  task automatic drive_line(input int ln, input int p0, input int p1, input logic [7:0] d);
    logic       hs, vs;
    logic [7:0] dd;
    for (int p = p0; p < p1; p++) begin
      @(negedge clk);
      hs = (p >= HS);
      vs = (ln >= VS);
      dd = (p >= HST && p < HST + HA && ln >= VST && ln < VST + VA) ? (d & 8'h77) : 8'h00;
      vga_in = {hs, dd[6:4], vs, dd[2:0]};
      if (ln == 0 && p == 0) t_vs = cyc;
    end
  endtask

  task automatic drive_frame(input int nlines, input logic [7:0] d, input int short_ln);
    for (int ln = 0; ln < nlines; ln++) begin
      drive_line(ln, 0, (ln == short_ln) ? HT - 1 : HT, d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    vga_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", int'(outs_any()), 0);
    chk("reset_frame_crc", int'(frame_crc), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] dbits;
    logic [5:0] rgb;
  } vec_t;

  vec_t tbl[7];
  int   s_pv, s_le, s_fe, s_fcv, s_fs, s_rgb;

  initial begin
    tbl[0] = '{8'h01, 6'b100000};
    tbl[1] = '{8'h10, 6'b010000};
    tbl[2] = '{8'h02, 6'b001000};
    tbl[3] = '{8'h20, 6'b000100};
    tbl[4] = '{8'h04, 6'b000010};
    tbl[5] = '{8'h40, 6'b000001};
    tbl[6] = '{8'h63, 6'b101101};

    // Clean frames with pixel 101101 (bus data 0x63).
    do_reset();
    exp_rgb = 6'b101101;
    s_pv = pv_n; s_fcv = fcv_n; s_fs = fs_n;
    drive_line(VT - 1, 0, HT, 8'h00);
    chk("locked_before_vsync", int'(locked), 0);
    drive_frame(VT, 8'h63, -1);
    chk("lock_latency", lock_cyc, t_vs + 3);
    chk("frame_start_first", fs_n - s_fs, 1);
    drive_frame(VT, 8'h63, -1);
    drive_frame(VT, 8'h63, -1);
    chk("clean_pix_count", pv_n - s_pv, 3 * HA * VA);
    chk("clean_seq", seq_bad, 0);
    chk("clean_rgb", rgb_bad, 0);
    chk("clean_last_x", last_x, HA - 1);
    chk("clean_last_y", last_y, VA - 1);
    chk("clean_crc_pulses", fcv_n - s_fcv, 3);
    chk("clean_crc", int'(frame_crc), int'(crc_model(HA * VA, 6'b101101)));
    chk("clean_err_count", int'(err_count), 0);
    chk("clean_locked", int'(locked), 1);

    // Bit unscramble, one frame per table entry.
    for (int i = 0; i < 7; i++) begin
      exp_rgb = tbl[i].rgb;
      s_rgb = rgb_bad; s_fcv = fcv_n;
      drive_frame(VT, tbl[i].dbits, -1);
      chk($sformatf("unscr%0d_rgb", i), rgb_bad - s_rgb, 0);
      chk($sformatf("unscr%0d_last", i), int'(last_rgb), int'(tbl[i].rgb));
      chk($sformatf("unscr%0d_crc_pulse", i), fcv_n - s_fcv, 1);
      chk($sformatf("unscr%0d_crc", i), int'(frame_crc), int'(crc_model(HA * VA, tbl[i].rgb)));
    end

    // Short line (29 clocks) on active line 7.
    exp_rgb = 6'b101101;
    s_pv = pv_n; s_le = le_n; s_fcv = fcv_n;
    drive_frame(VT, 8'h63, 7);
    chk("short_line_err", le_n - s_le, 1);
    chk("short_locked", int'(locked), 0);
    chk("short_pix_count", pv_n - s_pv, 3 * HA);
    chk("short_no_crc", fcv_n - s_fcv, 0);
    chk("short_err_count", int'(err_count), 1);
    s_pv = pv_n; s_fcv = fcv_n;
    drive_frame(VT, 8'h63, -1);
    chk("short_relock", int'(locked), 1);
    chk("short_relock_pix", pv_n - s_pv, HA * VA);
    chk("short_relock_crc", int'(frame_crc), int'(crc_model(HA * VA, 6'b101101)));
    chk("short_relock_pulse", fcv_n - s_fcv, 1);

    // Long frame (16 lines), then a frame whose last line is also short.
    do_reset();
    drive_line(VT - 1, 0, HT, 8'h00);
    s_le = le_n; s_fe = fe_n; s_fcv = fcv_n;
    drive_frame(VT, 8'h63, -1);
    drive_frame(VT + 1, 8'h63, -1);
    drive_frame(VT, 8'h63, -1);
    chk("long_frame_err", fe_n - s_fe, 1);
    chk("long_frame_err_time", fe_cyc, t_vs + 3);
    chk("long_no_line_err", le_n - s_le, 0);
    chk("long_locked", int'(locked), 1);
    chk("long_err_count", int'(err_count), 1);
    chk("long_crc_pulses", fcv_n - s_fcv, 3);
    drive_frame(VT + 1, 8'h63, VT);
    s_pv = pv_n;
    drive_frame(VT, 8'h63, -1);
    chk("both_err_count", int'(err_count), 3);
    chk("both_line_err", le_n - s_le, 1);
    chk("both_frame_err", fe_n - s_fe, 2);
    chk("both_le_time", le_cyc, t_vs + 3);
    chk("both_fe_time", fe_cyc, t_vs + 3);
    chk("both_unlocked", int'(locked), 0);
    chk("both_no_pix", pv_n - s_pv, 0);

    // Reset at line 7, pixel 15 of a locked frame.
    drive_frame(VT, 8'h63, -1);
    for (int ln = 0; ln < 7; ln++) drive_line(ln, 0, HT, 8'h63);
    drive_line(7, 0, HST + 5, 8'h63);
    chk("pre_reset_valid", int'(pix_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_zero_now", int'(outs_any()), 0);
    drive_line(7, HST + 5, HST + 15, 8'h63);
    chk("midrst_zero_held", int'(outs_any()), 0);
    #1 rst_n = 1'b1;
    s_pv = pv_n; s_fcv = fcv_n;
    drive_line(7, HST + 15, HT, 8'h63);
    for (int ln = 8; ln < VT; ln++) drive_line(ln, 0, HT, 8'h63);
    chk("midrst_no_pix", pv_n - s_pv, 0);
    chk("midrst_no_crc", fcv_n - s_fcv, 0);
    chk("midrst_crc_zero", int'(frame_crc), 0);
    chk("midrst_unlocked", int'(locked), 0);
    drive_frame(VT, 8'h63, -1);
    chk("midrst_relock_pix", pv_n - s_pv, HA * VA);
    chk("midrst_relock_crc", int'(frame_crc), int'(crc_model(HA * VA, 6'b101101)));
    chk("midrst_relock_pulse", fcv_n - s_fcv, 1);

    // Error saturation: 300 short blanking lines.
    do_reset();
    s_le = le_n;
    drive_line(VT - 1, 0, HT, 8'h00);
    for (int i = 0; i < 300; i++) drive_line(VT - 1, 0, HT - 1, 8'h00);
    drive_line(VT - 1, 0, HT, 8'h00);
    chk("sat_line_errs", le_n - s_le, 300);
    chk("sat_err_count", int'(err_count), 255);
    for (int i = 0; i < 5; i++) drive_line(VT - 1, 0, HT - 1, 8'h00);
    drive_line(VT - 1, 0, HT, 8'h00);
    chk("sat_more_errs", le_n - s_le, 305);
    chk("sat_err_hold", int'(err_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
